// File: rtl/dtw_result_unpacker.sv
// Drains the 3-word DTW sink FIFO records into one classified result with saturating counters.
// Optional best-record tracking is enabled by defining DTW_RESULT_BEST_EN.
module dtw_result_unpacker #(
  parameter int dtw_dwidth = 16,
  parameter int axi_dwidth = 32,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [dtw_dwidth-1:0] thresh,
  input  logic                  stat_clr,
  output logic                  fifo_rden,
  input  logic                  fifo_empty,
  input  logic [axi_dwidth-1:0] fifo_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [axi_dwidth-1:0] res_qid,
  output logic [axi_dwidth-1:0] res_position,
  output logic [dtw_dwidth-1:0] res_minval,
  output logic                  res_hit,
  output logic [CNT_W-1:0]      rec_count,
  output logic [CNT_W-1:0]      hit_count,
  output logic                  err_format,
  output logic                  busy
`ifdef DTW_RESULT_BEST_EN
  ,
  output logic                  best_valid,
  output logic [axi_dwidth-1:0] best_qid,
  output logic [axi_dwidth-1:0] best_position,
  output logic [dtw_dwidth-1:0] best_minval
`endif
);

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_READ    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_EMIT    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [axi_dwidth-dtw_dwidth-1:0] UPPER_ZERO = {(axi_dwidth-dtw_dwidth){1'b0}};

  state_t     state;
  logic [1:0] word_idx;

  // Record-assembly FSM, counters and sticky status; stat_clr is applied last so it wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_WAIT;
      word_idx     <= 2'd0;
      fifo_rden    <= 1'b0;
      res_valid    <= 1'b0;
      res_qid      <= {axi_dwidth{1'b0}};
      res_position <= {axi_dwidth{1'b0}};
      res_minval   <= {dtw_dwidth{1'b0}};
      res_hit      <= 1'b0;
      rec_count    <= {CNT_W{1'b0}};
      hit_count    <= {CNT_W{1'b0}};
      err_format   <= 1'b0;
      busy         <= 1'b0;
`ifdef DTW_RESULT_BEST_EN
      best_valid    <= 1'b0;
      best_qid      <= {axi_dwidth{1'b0}};
      best_position <= {axi_dwidth{1'b0}};
      best_minval   <= {dtw_dwidth{1'b0}};
`endif
    end else begin
      case (state)
        ST_WAIT: begin
          // A started record finishes regardless of en.
          if (!fifo_empty && (en || word_idx != 2'd0)) begin
            state     <= ST_READ;
            fifo_rden <= 1'b1;
            busy      <= 1'b1;
          end else begin
            fifo_rden <= 1'b0;
            busy      <= (word_idx != 2'd0);
          end
        end
        ST_READ: begin
          fifo_rden <= 1'b0;
          state     <= ST_CAPTURE;
          busy      <= 1'b1;
        end
        ST_CAPTURE: begin
          fifo_rden <= 1'b0;
          busy      <= 1'b1;
          case (word_idx)
            2'd0: begin
              res_qid  <= fifo_data;
              word_idx <= 2'd1;
              state    <= ST_WAIT;
            end
            2'd1: begin
              res_position <= fifo_data;
              word_idx     <= 2'd2;
              state        <= ST_WAIT;
            end
            2'd2: begin
              res_minval <= fifo_data[dtw_dwidth-1:0];
              res_hit    <= (fifo_data[dtw_dwidth-1:0] <= thresh);
              if (fifo_data[axi_dwidth-1:dtw_dwidth] != UPPER_ZERO) begin
                err_format <= 1'b1;
              end else begin
                err_format <= err_format;
              end
              word_idx  <= 2'd0;
              res_valid <= 1'b1;
              state     <= ST_EMIT;
            end
            default: begin
              word_idx <= 2'd0;
              state    <= ST_WAIT;
            end
          endcase
        end
        ST_EMIT: begin
          fifo_rden <= 1'b0;
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_WAIT;
            busy      <= 1'b0;
            if (rec_count != CNT_MAX) begin
              rec_count <= rec_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
              rec_count <= rec_count;
            end
            if (res_hit && hit_count != CNT_MAX) begin
              hit_count <= hit_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
              hit_count <= hit_count;
            end
`ifdef DTW_RESULT_BEST_EN
            // Strict less-than keeps the earliest record on ties.
            if (!best_valid || res_minval < best_minval) begin
              best_valid    <= 1'b1;
              best_qid      <= res_qid;
              best_position <= res_position;
              best_minval   <= res_minval;
            end else begin
              best_valid <= best_valid;
            end
`endif
          end else begin
            res_valid <= 1'b1;
          end
        end
        default: begin
          state     <= ST_WAIT;
          word_idx  <= 2'd0;
          fifo_rden <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
      if (stat_clr) begin
        rec_count  <= {CNT_W{1'b0}};
        hit_count  <= {CNT_W{1'b0}};
        err_format <= 1'b0;
`ifdef DTW_RESULT_BEST_EN
        best_valid    <= 1'b0;
        best_qid      <= {axi_dwidth{1'b0}};
        best_position <= {axi_dwidth{1'b0}};
        best_minval   <= {dtw_dwidth{1'b0}};
`endif
      end
    end
  end

endmodule

// File: tb/tb_dtw_result_unpacker.sv
// Directed and randomized bench for dtw_result_unpacker against a record-level reference model.
module tb_dtw_result_unpacker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] thresh = 16'h0;
  logic        stat_clr = 1'b0;
  logic        fifo_rden;
  logic        fifo_empty;
  logic [31:0] fifo_data = 32'h0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_qid, res_position;
  logic [15:0] res_minval;
  logic        res_hit;
  logic [15:0] rec_count, hit_count;
  logic        err_format, busy;
`ifdef DTW_RESULT_BEST_EN
  logic        best_valid;
  logic [31:0] best_qid, best_position;
  logic [15:0] best_minval;
`endif

  dtw_result_unpacker dut (
    .clk(clk), .rst(rst), .en(en), .thresh(thresh), .stat_clr(stat_clr),
    .fifo_rden(fifo_rden), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_qid(res_qid),
    .res_position(res_position), .res_minval(res_minval), .res_hit(res_hit),
    .rec_count(rec_count), .hit_count(hit_count), .err_format(err_format), .busy(busy)
`ifdef DTW_RESULT_BEST_EN
    , .best_valid(best_valid), .best_qid(best_qid), .best_position(best_position),
    .best_minval(best_minval)
`endif
  );

  always #5 clk = ~clk;

  // Standard (non-FWFT) sink FIFO model
  logic [31:0] fmem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (fifo_rden && (rd_ptr != wr_ptr)) begin
      fifo_data <= fmem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Reference model: words grouped in threes become expected records
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] part [$];
  logic [31:0] e_qid [$];
  logic [31:0] e_pos [$];
  logic [15:0] e_min [$];
  logic        e_hit [$];
  logic        e_err [$];
  int m_rec = 0, m_hit = 0;
  logic m_err = 1'b0;
  logic m_bvalid = 1'b0;
  logic [31:0] m_bqid = 32'h0;
  logic [15:0] m_bmin = 16'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    fmem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1;
    part.push_back(w);
    if (part.size() == 3) begin
      e_qid.push_back(part[0]);
      e_pos.push_back(part[1]);
      e_min.push_back(part[2][15:0]);
      e_hit.push_back(part[2][15:0] <= thresh);
      e_err.push_back(part[2][31:16] != 16'h0);
      part.delete();
    end
  endtask

  task automatic push_rec(input logic [31:0] q, input logic [31:0] p, input logic [31:0] m);
    push(q); push(p); push(m);
  endtask

  task automatic clear_model_stats();
    m_rec = 0; m_hit = 0; m_err = 1'b0; m_bvalid = 1'b0; m_bqid = 32'h0; m_bmin = 16'h0;
  endtask

  // Waits for a record, checks it, holds res_ready low for 'stall' cycles, then completes the handshake
  task automatic expect_record(input string tag, input int stall);
    int n;
    logic [31:0] q0, p0;
    logic [15:0] m0;
    n = 0;
    while (!res_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, {31'h0, res_valid}, 32'h1);
    if (!res_valid || e_qid.size() == 0) return;
    m_err = m_err | e_err[0];
    check({tag, "_qid"}, res_qid, e_qid[0]);
    check({tag, "_pos"}, res_position, e_pos[0]);
    check({tag, "_min"}, {16'h0, res_minval}, {16'h0, e_min[0]});
    check({tag, "_hit"}, {31'h0, res_hit}, {31'h0, e_hit[0]});
    check({tag, "_err"}, {31'h0, err_format}, {31'h0, m_err});
    q0 = res_qid; p0 = res_position; m0 = res_minval;
    for (int i = 0; i < stall; i++) begin
      res_ready = 1'b0;
      @(negedge clk);
      check({tag, "_stall_valid"}, {31'h0, res_valid}, 32'h1);
      check({tag, "_stall_rden"}, {31'h0, fifo_rden}, 32'h0);
      check({tag, "_stall_hold"}, res_qid ^ res_position ^ {16'h0, res_minval}, q0 ^ p0 ^ {16'h0, m0});
    end
    res_ready = 1'b1;
    @(posedge clk);
    if (m_rec < 65535) m_rec++;
    if (e_hit[0] && m_hit < 65535) m_hit++;
    if (!m_bvalid || e_min[0] < m_bmin) begin
      m_bvalid = 1'b1; m_bqid = e_qid[0]; m_bmin = e_min[0];
    end
    void'(e_qid.pop_front()); void'(e_pos.pop_front()); void'(e_min.pop_front());
    void'(e_hit.pop_front()); void'(e_err.pop_front());
    @(negedge clk);
    check({tag, "_drop"}, {31'h0, res_valid}, 32'h0);
    check({tag, "_rec_cnt"}, {16'h0, rec_count}, m_rec);
    check({tag, "_hit_cnt"}, {16'h0, hit_count}, m_hit);
`ifdef DTW_RESULT_BEST_EN
    check({tag, "_best_valid"}, {31'h0, best_valid}, {31'h0, m_bvalid});
    check({tag, "_best_qid"}, best_qid, m_bqid);
    check({tag, "_best_min"}, {16'h0, best_minval}, {16'h0, m_bmin});
`endif
  endtask

  task automatic wait_drained(input string tag);
    int n;
    n = 0;
    while (rd_ptr != wr_ptr && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, rd_ptr, wr_ptr);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_stat_clr();
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    clear_model_stats();
  endtask

  initial begin
    int saved_rd;
    logic [15:0] mv;
    logic [31:0] w2;
    repeat (3) @(negedge clk);
    check("reset_valid", {31'h0, res_valid}, 32'h0);
    check("reset_rden", {31'h0, fifo_rden}, 32'h0);
    check("reset_counts", {rec_count, hit_count}, 32'h0);
    check("reset_flags", {30'h0, err_format, busy}, 32'h0);
    check("reset_qid", res_qid, 32'h0);
    rst = 1'b0;
    en = 1'b1;
    @(negedge clk);

    // Basic record, hit
    thresh = 16'h0040;
    push_rec(32'h7, 32'h1F4, 32'h0000_0032);
    expect_record("basic", 0);
    check("basic_busy", {31'h0, busy}, 32'h0);

    // Format error is sticky until stat_clr
    push_rec(32'h7, 32'h1F4, 32'h0001_0032);
    expect_record("fmt", 0);
    push_rec(32'h8, 32'h10, 32'h0000_0041);
    expect_record("fmt_sticky", 0);
    pulse_stat_clr();
    check("clr_counts", {rec_count, hit_count}, 32'h0);
    check("clr_err", {31'h0, err_format}, 32'h0);

    // Back-pressure with a second record queued behind
    res_ready = 1'b0;
    push_rec(32'h11, 32'h22, 32'h0000_0010);
    push_rec(32'h33, 32'h44, 32'h0000_0090);
    expect_record("stall_a", 20);
    expect_record("stall_b", 0);

    // en dropped mid-record: record completes, no new reads while en is low
    push(32'h55); push(32'h66);
    wait_drained("en_part");
    en = 1'b0;
    repeat (4) @(negedge clk);
    check("en_busy", {31'h0, busy}, 32'h1);
    push(32'h0000_0040);
    expect_record("en_finish", 0);
    push_rec(32'h77, 32'h88, 32'h0000_0041);
    saved_rd = rd_ptr;
    repeat (30) @(negedge clk);
    check("en_no_read", rd_ptr, saved_rd);
    check("en_idle", {30'h0, res_valid, busy}, 32'h0);
    en = 1'b1;
    expect_record("en_resume", 0);

    // Reset mid-record discards the partial record
    push(32'h99);
    wait_drained("rst_part");
    rst = 1'b1;
    part.delete();
    clear_model_stats();
    @(negedge clk);
    check("rst_mid_outputs", {28'h0, res_valid, busy, err_format, fifo_rden}, 32'h0);
    check("rst_mid_counts", {rec_count, hit_count}, 32'h0);
    rst = 1'b0;
    push_rec(32'hA1, 32'hA2, 32'h0000_0005);
    expect_record("rst_new", 0);
    check("rst_new_rec", {16'h0, rec_count}, 32'h1);

    // stat_clr coinciding with the handshake wins
    res_ready = 1'b0;
    push_rec(32'hB1, 32'hB2, 32'h0000_0001);
    while (!res_valid && rd_ptr < 100000) @(negedge clk);
    res_ready = 1'b1;
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    clear_model_stats();
    void'(e_qid.pop_front()); void'(e_pos.pop_front()); void'(e_min.pop_front());
    void'(e_hit.pop_front()); void'(e_err.pop_front());
    check("clr_hs_counts", {rec_count, hit_count}, 32'h0);
    check("clr_hs_valid", {31'h0, res_valid}, 32'h0);

`ifdef DTW_RESULT_BEST_EN
    // Best tracking: ties keep the earlier record
    pulse_stat_clr();
    push_rec(32'h100, 32'h1, 32'h50); expect_record("best0", 0);
    push_rec(32'h101, 32'h2, 32'h20); expect_record("best1", 0);
    push_rec(32'h102, 32'h3, 32'h20); expect_record("best2", 0);
    push_rec(32'h103, 32'h4, 32'h90); expect_record("best3", 0);
    check("best_dir_min", {16'h0, best_minval}, 32'h20);
    check("best_dir_qid", best_qid, 32'h101);
    check("best_dir_pos", best_position, 32'h2);
`endif

    // Randomized records with random threshold and back-pressure
    for (int i = 0; i < 24; i++) begin
      thresh = 16'($urandom);
      mv = (i % 4 == 0) ? thresh : 16'($urandom);
      w2 = ($urandom_range(0, 3) == 0) ? {16'($urandom_range(1, 65535)), mv} : {16'h0, mv};
      res_ready = 1'b0;
      push_rec($urandom, $urandom, w2);
      expect_record("rand", int'($urandom_range(0, 5)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
